// File: rtl/mem_link_pkg.sv
// rtl/mem_link_pkg.sv - shared field layout and types for the merged readout link word
package mem_link_pkg;

    localparam int SRC_HI = 47;
    localparam int SRC_LO = 44;
    localparam logic [3:0] HDR_SRC = 4'hF;
    localparam int DATA_W = 44;
    localparam int BX_W   = 3;
    localparam int CNT_W  = 6;
    localparam int BX_LO  = 0;
    localparam int WORD_W = SRC_HI + 1;

    typedef logic [WORD_W-1:0] link_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } demux_state_t;

endpackage

// File: rtl/mem_wr_counter.sv
// rtl/mem_wr_counter.sv - per-memory saturating item counter with sticky overflow flag
module mem_wr_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow
);

    assign full = &count;

    // overflow survives clear so a dropped write stays visible across events
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_writein_demux.sv
// rtl/mem_writein_demux.sv - scatters merged link words into NMEM memories; optional MEM_WRITEIN_WATCHDOG_EN
module mem_writein_demux #(
    parameter int NMEM       = 12,
    parameter int DATA_W     = 44,
    parameter int CNT_W      = 6,
    parameter int PAGE_W     = 1,
    parameter int CLK_PER_BX = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [47:0]              stream_in,
    input  logic                     valid_in,
    input  logic                     send_BX_in,
    output logic [NMEM-1:0]          wr_en,
    output logic [PAGE_W+CNT_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [NMEM*CNT_W-1:0]    number_out,
    output logic [2:0]               bx_out,
    output logic                     event_done,
    output logic [NMEM-1:0]          overflow,
`ifdef MEM_WRITEIN_WATCHDOG_EN
    output logic                     timeout,
`endif
    output logic                     err_bad_src
);

    import mem_link_pkg::*;

    demux_state_t      state;
    logic [BX_W-1:0]   cur_bx;
    logic [PAGE_W-1:0] page;

    logic [3:0]        src;
    logic [BX_W-1:0]   hdr_bx;
    logic              wd_fire;
    logic              clear;
    logic              data_ok;
    logic [NMEM-1:0]   inc;
    logic [NMEM-1:0]   full;
    logic [CNT_W-1:0]  cnt [NMEM];

    assign src    = stream_in[SRC_HI:SRC_LO];
    assign hdr_bx = stream_in[BX_LO +: BX_W];

`ifdef MEM_WRITEIN_WATCHDOG_EN
    logic [6:0] wd_cnt;
    assign wd_fire = (state == ST_RUN) && !send_BX_in && (wd_cnt == 7'(CLK_PER_BX - 1));
`else
    assign wd_fire = 1'b0;
`endif

    // a forced close behaves like a header, so a coincident data word is dropped
    assign clear   = send_BX_in || wd_fire;
    assign data_ok = valid_in && !send_BX_in && !wd_fire && (state == ST_RUN);

    for (genvar g = 0; g < NMEM; g++) begin : g_cnt
        assign inc[g] = data_ok && (32'(src) == g);

        mem_wr_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .inc      (inc[g]),
            .count    (cnt[g]),
            .full     (full[g]),
            .overflow (overflow[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_bx      <= '0;
            page        <= '0;
            wr_en       <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            number_out  <= '0;
            bx_out      <= '0;
            event_done  <= 1'b0;
            err_bad_src <= 1'b0;
`ifdef MEM_WRITEIN_WATCHDOG_EN
            wd_cnt      <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            event_done <= 1'b0;

            if (send_BX_in) begin
                cur_bx <= hdr_bx;
                page   <= hdr_bx[PAGE_W-1:0];
                state  <= ST_RUN;
                if (state == ST_RUN) begin
                    for (int i = 0; i < NMEM; i++) begin
                        number_out[i*CNT_W +: CNT_W] <= cnt[i];
                    end
                    bx_out     <= cur_bx;
                    event_done <= 1'b1;
                end
            end else if (wd_fire) begin
                for (int i = 0; i < NMEM; i++) begin
                    number_out[i*CNT_W +: CNT_W] <= cnt[i];
                end
                bx_out     <= cur_bx;
                event_done <= 1'b1;
                cur_bx     <= cur_bx + 1'b1;
                page       <= page + 1'b1;
            end else if (data_ok) begin
                if (32'(src) < NMEM) begin
                    if (!full[src]) begin
                        wr_en   <= NMEM'(1) << src;
                        wr_addr <= {page, cnt[src]};
                        wr_data <= stream_in[DATA_W-1:0];
                    end
                end else if (src != HDR_SRC) begin
                    err_bad_src <= 1'b1;
                end
            end

`ifdef MEM_WRITEIN_WATCHDOG_EN
            if (send_BX_in || wd_fire || state == ST_IDLE) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                timeout <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_writein_demux.sv
// tb/tb_mem_writein_demux.sv - directed vector bench for mem_writein_demux
module tb_mem_writein_demux;

    localparam int NMEM = 12;
    localparam int CNT_W = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [47:0]           stream_in;
    logic                  valid_in;
    logic                  send_BX_in;
    logic [NMEM-1:0]       wr_en;
    logic [6:0]            wr_addr;
    logic [43:0]           wr_data;
    logic [NMEM*CNT_W-1:0] number_out;
    logic [2:0]            bx_out;
    logic                  event_done;
    logic [NMEM-1:0]       overflow;
    logic                  err_bad_src;
`ifdef MEM_WRITEIN_WATCHDOG_EN
    logic                  timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_writein_demux #(
        .NMEM(NMEM), .DATA_W(44), .CNT_W(CNT_W), .PAGE_W(1), .CLK_PER_BX(100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stream_in   (stream_in),
        .valid_in    (valid_in),
        .send_BX_in  (send_BX_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .number_out  (number_out),
        .bx_out      (bx_out),
        .event_done  (event_done),
        .overflow    (overflow),
`ifdef MEM_WRITEIN_WATCHDOG_EN
        .timeout     (timeout),
`endif
        .err_bad_src (err_bad_src)
    );

    typedef struct {
        logic        hdr;
        logic        vld;
        logic [47:0] word;
        logic [11:0] exp_en;
        logic [6:0]  exp_addr;
        logic [43:0] exp_data;
        logic        exp_done;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [47:0] mk(input logic [3:0] s, input logic [43:0] p);
        return {s, p};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] num(input int i);
        return number_out[i*CNT_W +: CNT_W];
    endfunction

    task automatic drive(input logic hdr, input logic vld, input logic [47:0] w);
        send_BX_in = hdr;
        valid_in   = vld;
        stream_in  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 48'h0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        send_BX_in = 1'b0;
        valid_in   = 1'b0;
        stream_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, mk(4'hF, 44'd3),     12'h000, 7'h00, 44'h0,   1'b0};
        vecs[1]  = '{1'b0, 1'b1, mk(4'd0, 44'hAAA),   12'h001, 7'h40, 44'hAAA, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, mk(4'd0, 44'hBBB),   12'h001, 7'h41, 44'hBBB, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 48'h0,               12'h000, 7'h00, 44'h0,   1'b0};
        vecs[4]  = '{1'b0, 1'b1, mk(4'd5, 44'h123),   12'h020, 7'h40, 44'h123, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, mk(4'hF, 44'd4),     12'h000, 7'h00, 44'h0,   1'b1};
        vecs[6]  = '{1'b0, 1'b1, mk(4'd0, 44'h5),     12'h001, 7'h00, 44'h5,   1'b0};
        vecs[7]  = '{1'b0, 1'b1, mk(4'd13, 44'h77),   12'h000, 7'h00, 44'h0,   1'b0};
        vecs[8]  = '{1'b1, 1'b1, mk(4'd2, 44'hF05),   12'h000, 7'h00, 44'h0,   1'b1};
        vecs[9]  = '{1'b0, 1'b1, mk(4'hF, 44'h99),    12'h000, 7'h00, 44'h0,   1'b0};
        vecs[10] = '{1'b0, 1'b1, mk(4'd2, 44'hC0DE),  12'h004, 7'h40, 44'hC0DE, 1'b0};

        // reset state
        do_reset();
        chk("rst_wr_en", 72'(wr_en), 72'h0);
        chk("rst_addr", 72'(wr_addr), 72'h0);
        chk("rst_data", 72'(wr_data), 72'h0);
        chk("rst_number", 72'(number_out), 72'h0);
        chk("rst_bx", 72'(bx_out), 72'h0);
        chk("rst_done", 72'(event_done), 72'h0);
        chk("rst_ovf", 72'(overflow), 72'h0);
        chk("rst_bad", 72'(err_bad_src), 72'h0);

        // data before any header is discarded
        drive(1'b0, 1'b1, mk(4'd0, 44'h1));
        chk("pre_wr_en0", 72'(wr_en), 72'h0);
        drive(1'b0, 1'b1, mk(4'd3, 44'h2));
        chk("pre_wr_en3", 72'(wr_en), 72'h0);
        drive(1'b1, 1'b0, mk(4'hF, 44'd1));
        chk("first_hdr_done", 72'(event_done), 72'h0);
        drive(1'b1, 1'b0, mk(4'hF, 44'd2));
        chk("b2b_done", 72'(event_done), 72'h1);
        chk("b2b_number", 72'(number_out), 72'h0);
        chk("b2b_bx", 72'(bx_out), 72'h1);

        // main table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].hdr, vecs[i].vld, vecs[i].word);
            chk($sformatf("v%0d_wr_en", i), 72'(wr_en), 72'(vecs[i].exp_en));
            chk($sformatf("v%0d_addr", i), 72'(wr_addr), 72'(vecs[i].exp_addr));
            chk($sformatf("v%0d_data", i), 72'(wr_data), 72'(vecs[i].exp_data));
            chk($sformatf("v%0d_done", i), 72'(event_done), 72'(vecs[i].exp_done));
            if (i == 5) begin
                chk("ev1_num0", 72'(num(0)), 72'd2);
                chk("ev1_num5", 72'(num(5)), 72'd1);
                chk("ev1_num1", 72'(num(1)), 72'd0);
                chk("ev1_bx", 72'(bx_out), 72'd3);
            end
            if (i == 7) chk("bad_src_set", 72'(err_bad_src), 72'h1);
            if (i == 8) begin
                chk("ev2_num0", 72'(num(0)), 72'd1);
                chk("ev2_num2", 72'(num(2)), 72'd0);
                chk("ev2_bx", 72'(bx_out), 72'd4);
            end
        end
        idle();
        chk("idle_after_wr_en", 72'(wr_en), 72'h0);
        chk("bad_src_sticky", 72'(err_bad_src), 72'h1);
        chk("no_ovf", 72'(overflow), 72'h0);

        // saturation at 63 items
        do_reset();
        drive(1'b1, 1'b0, mk(4'hF, 44'd0));
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, mk(4'd11, 44'(i + 16)));
            if (i < 63) begin
                chk($sformatf("sat_en%0d", i), 72'(wr_en), 72'h800);
                chk($sformatf("sat_addr%0d", i), 72'(wr_addr), 72'(i));
            end else begin
                chk("sat_en_drop", 72'(wr_en), 72'h0);
            end
        end
        idle();
        chk("sat_ovf", 72'(overflow), 72'h800);
        drive(1'b1, 1'b0, mk(4'hF, 44'd1));
        chk("sat_done", 72'(event_done), 72'h1);
        chk("sat_num11", 72'(num(11)), 72'd63);
        drive(1'b0, 1'b1, mk(4'd11, 44'h3));
        chk("sat_reopen_en", 72'(wr_en), 72'h800);
        chk("sat_reopen_addr", 72'(wr_addr), 72'h40);
        chk("sat_ovf_sticky", 72'(overflow), 72'h800);

        // reset mid-event
        do_reset();
        drive(1'b1, 1'b0, mk(4'hF, 44'd2));
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, mk(4'd7, 44'(i)));
        chk("mid_wr_addr", 72'(wr_addr), 72'h02);
        do_reset();
        chk("mid_rst_ovf", 72'(overflow), 72'h0);
        drive(1'b1, 1'b0, mk(4'hF, 44'd3));
        chk("mid_hdr_done", 72'(event_done), 72'h0);
        drive(1'b1, 1'b0, mk(4'hF, 44'd4));
        chk("mid_next_done", 72'(event_done), 72'h1);
        chk("mid_num7", 72'(num(7)), 72'd0);
        chk("mid_bx", 72'(bx_out), 72'd3);

`ifdef MEM_WRITEIN_WATCHDOG_EN
        do_reset();
        drive(1'b1, 1'b0, mk(4'hF, 44'd6));
        repeat (99) idle();
        chk("wd_not_yet", 72'(event_done), 72'h0);
        chk("wd_no_timeout", 72'(timeout), 72'h0);
        idle();
        chk("wd_done", 72'(event_done), 72'h1);
        chk("wd_bx", 72'(bx_out), 72'd6);
        chk("wd_timeout", 72'(timeout), 72'h1);
        drive(1'b0, 1'b1, mk(4'd0, 44'h9));
        chk("wd_page", 72'(wr_addr), 72'h40);
        drive(1'b1, 1'b0, mk(4'hF, 44'd0));
        chk("wd_next_bx", 72'(bx_out), 72'd7);
        chk("wd_next_num0", 72'(num(0)), 72'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
